interp_tile_seq: RTL and testbench
==================================

# interp_tile_seq

Tile scan sequencer for the PVR plane interpolator bank. It accepts one polygon/tile job and drives the shared `setup`, `x_ps` and `y_ps` inputs of every plane-interpolator instance (Z, U, V, colour planes). It re-runs setup at the start of each row, because the interpolator latches the row term `y_ps*FDDY + c` only while `setup` is high. It then sweeps the row's pixels behind a valid/ready pixel handshake and reports completion to the tile renderer.

## Interface
Parameters:
- `TILE_W`, 32: pixels per row; must be a power of two, at most 64.
- `TILE_H`, 32: rows per tile; must be a power of two, at most 64.
- `SETUP_CYCLES`, 4: cycles `setup` is held per row. This covers the multicycle divide path inside the interpolator; must be at least 1.
- `COORD_W`, 11: width of the screen coordinate.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `job_valid`, in, 1: a tile job is offered.
- `job_ready`, out, 1: sequencer is idle and will accept the job.
- `tile_x`, in, COORD_W: tile origin x; sampled on accept.
- `tile_y`, in, COORD_W: tile origin y; sampled on accept.
- `abort`, in, 1: cancel the current job.
- `setup`, out, 1: setup strobe to the interpolator bank.
- `x_ps`, out, COORD_W: pixel x to the interpolator bank.
- `y_ps`, out, COORD_W: pixel y to the interpolator bank.
- `pix_valid`, out, 1: the interpolator outputs for (`x_ps`, `y_ps`) are valid.
- `pix_ready`, in, 1: the downstream shader/tile buffer accepts the pixel.
- `pix_col`, out, log2(TILE_W): column index of the current pixel.
- `pix_row`, out, log2(TILE_H): row index of the current pixel.
- `pix_last`, out, 1: the current pixel is the final pixel of the tile.
- `done`, out, 1: one-cycle pulse when a tile completes normally.

## Operation
States: IDLE, SETUP, SCAN.

IDLE
- `job_ready` = 1 exactly when state is IDLE and `abort` = 0.
- An accept is `job_valid & job_ready`. On accept, latch `tile_x`/`tile_y`, clear `row` and `col`, load `scnt` = SETUP_CYCLES-1, and go to SETUP.

SETUP
- `setup` = 1.
- `x_ps` = base_x and `y_ps` = base_y + row; both held stable for the whole state.
- `scnt` decrements each cycle. When `scnt` = 0, go to SCAN with `col` = 0.

SCAN
- `setup` = 0, `pix_valid` = 1.
- `x_ps` = base_x + col; `y_ps` is unchanged from SETUP.
- A transfer is `pix_valid & pix_ready`. On a transfer:
  - `col` < TILE_W-1: `col` increments.
  - `col` = TILE_W-1 and `row` < TILE_H-1: `row` increments, `scnt` reloads, go to SETUP.
  - `col` = TILE_W-1 and `row` = TILE_H-1: go to IDLE and pulse `done` on the next cycle.
- While `pix_ready` = 0, `x_ps`, `y_ps`, `pix_col`, `pix_row` and `pix_last` hold stable. `pix_valid` is never withdrawn once asserted, except by abort or reset.

Arithmetic and flags
- Coordinate sums are COORD_W bits and wrap modulo 2^COORD_W. No saturation and no error flag.
- `pix_last` = (`col` = TILE_W-1) & (`row` = TILE_H-1) & `pix_valid`.

Abort
- Takes effect in any state: the next state is IDLE.
- `pix_valid` and `setup` drop on the following edge.
- No `done` pulse is produced. `abort` in IDLE has no effect, apart from masking `job_ready` for that cycle.
- `abort` coincident with a final transfer: abort wins; the pixel counts as transferred, but `done` is suppressed.

## Timing
- All outputs are registered except `job_ready` and `pix_last`, which are decoded from registered state.
- Reset values:
  - state IDLE.
  - `setup` 0, `pix_valid` 0, `done` 0.
  - `x_ps` 0, `y_ps` 0, `pix_col` 0, `pix_row` 0.
  - `job_ready` 1 while `abort` = 0.
- Accept at edge N: `setup` is high for edges N+1 … N+SETUP_CYCLES, and the first `pix_valid` appears at N+SETUP_CYCLES+1.
- With no backpressure each row costs SETUP_CYCLES+TILE_W cycles. A default tile takes 32×36 = 1152 cycles from accept to the last transfer; `done` is high on the following cycle.
- A new job may be accepted in the same cycle `done` is high. It can be back-to-back because IDLE is reached at the `done` edge.
- Reset asserted mid-job forces all outputs to their reset values immediately (asynchronously). The in-flight job is discarded.

## Structure
- Shared package `pvr_pkg`:
  - the state enum (IDLE/SETUP/SCAN);
  - the default tile dimension constants;
  - `COORD_W`.
- Sub-module `seq_ctr`: a loadable down-counter with a zero flag, instantiated for the setup timer. Row and column counters stay inline.
- The interpolator instances are outside this block. Their `setup`, `x_ps` and `y_ps` are fanned out from this block's outputs.

## Test plan
- Reset, then a single job with `tile_x`=64, `tile_y`=32 and `pix_ready` tied 1 → the first pixel is (64,32) at accept+5. There are exactly 1024 transfers, rows ascending and columns ascending. `setup` is high for 4 cycles before each row, with `y_ps` = 32+row. `done` pulses once at accept+1153.
- Random `pix_ready` backpressure (50%) → coordinates and indices hold while stalled. There is no duplicated or skipped pixel, and the transfer count is still 1024.
- Wrap case with `tile_x`=2032, `tile_y`=2040 → `x_ps` runs 2032…2047, 0…15. `y_ps` wraps from 2047 to 0 at row 8.
- `abort` during SETUP of row 5, and separately during a stalled SCAN → IDLE on the next cycle. `pix_valid`/`setup` are 0 and there is no `done`. `job_ready` is 1 on the cycle after abort drops.
- Back-to-back jobs with `job_valid` held high → the second job is accepted on the `done` cycle, and its first `setup` follows on the next cycle.
- Asynchronous `reset` pulse mid-row between clock edges → the outputs clear immediately, and the block accepts a new job after release.

Source files
------------

// File: rtl/pvr_pkg.sv
// Shared definitions for the PVR plane-interpolator tile sequencer.
package pvr_pkg;

    localparam int COORD_W          = 11;
    localparam int TILE_W_DEF       = 32;
    localparam int TILE_H_DEF       = 32;
    localparam int SETUP_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN
    } state_e;

endpackage

// File: rtl/seq_ctr.sv
// Loadable down-counter with a zero flag; times the per-row setup window.
module seq_ctr #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/interp_tile_seq.sv
// Tile scan sequencer: per-row setup strobe, then a valid/ready pixel sweep
// driving the shared setup/x_ps/y_ps inputs of the plane-interpolator bank.
module interp_tile_seq #(
    parameter int TILE_W       = pvr_pkg::TILE_W_DEF,
    parameter int TILE_H       = pvr_pkg::TILE_H_DEF,
    parameter int SETUP_CYCLES = pvr_pkg::SETUP_CYCLES_DEF,
    parameter int COORD_W      = pvr_pkg::COORD_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [COORD_W-1:0]        tile_x,
    input  logic [COORD_W-1:0]        tile_y,
    input  logic                      abort,
    output logic                      setup,
    output logic [COORD_W-1:0]        x_ps,
    output logic [COORD_W-1:0]        y_ps,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [$clog2(TILE_W)-1:0] pix_col,
    output logic [$clog2(TILE_H)-1:0] pix_row,
    output logic                      pix_last,
    output logic                      done
);

    import pvr_pkg::*;

    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);
    localparam int SW = $clog2(SETUP_CYCLES + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(TILE_H - 1);
    localparam logic [SW-1:0] SCNT_RELOAD = SW'(SETUP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   base_x_q, base_x_d;
    logic [COORD_W-1:0]   base_y_q, base_y_d;
    logic [COORD_W-1:0]   x_ps_q, x_ps_d;
    logic [COORD_W-1:0]   y_ps_q, y_ps_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 setup_q, setup_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 done_q, done_d;

    logic                 scnt_load;
    logic                 scnt_dec;
    logic                 scnt_zero;
    logic                 accept;
    logic                 xfer;

    seq_ctr #(
        .W (SW)
    ) u_setup_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (scnt_load),
        .load_val_i (SCNT_RELOAD),
        .dec_i      (scnt_dec),
        .zero_o     (scnt_zero)
    );

    assign job_ready = (state_q == ST_IDLE) & ~abort;
    assign accept    = job_valid & job_ready;
    assign xfer      = pix_valid_q & pix_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        x_ps_d      = x_ps_q;
        y_ps_d      = y_ps_q;
        col_d       = col_q;
        row_d       = row_q;
        setup_d     = setup_q;
        pix_valid_d = pix_valid_q;
        done_d      = 1'b0;
        scnt_load   = 1'b0;
        scnt_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SETUP;
                    base_x_d  = tile_x;
                    base_y_d  = tile_y;
                    x_ps_d    = tile_x;
                    y_ps_d    = tile_y;
                    col_d     = '0;
                    row_d     = '0;
                    setup_d   = 1'b1;
                    scnt_load = 1'b1;
                end
            end

            ST_SETUP: begin
                scnt_dec = 1'b1;
                if (scnt_zero) begin
                    state_d     = ST_SCAN;
                    setup_d     = 1'b0;
                    pix_valid_d = 1'b1;
                    col_d       = '0;
                    x_ps_d      = base_x_q;
                end
            end

            ST_SCAN: begin
                if (xfer) begin
                    if (col_q != COL_LAST) begin
                        col_d  = col_q + CW'(1);
                        x_ps_d = base_x_q + COORD_W'(col_d);
                    end else if (row_q != ROW_LAST) begin
                        // Next row: the interpolator must relatch its row term.
                        state_d     = ST_SETUP;
                        row_d       = row_q + RW'(1);
                        col_d       = '0;
                        setup_d     = 1'b1;
                        pix_valid_d = 1'b0;
                        scnt_load   = 1'b1;
                        x_ps_d      = base_x_q;
                        y_ps_d      = base_y_q + COORD_W'(row_d);
                    end else begin
                        state_d     = ST_IDLE;
                        pix_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a coincident final transfer.
        if (abort) begin
            state_d     = ST_IDLE;
            setup_d     = 1'b0;
            pix_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_x_q    <= '0;
            base_y_q    <= '0;
            x_ps_q      <= '0;
            y_ps_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            setup_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            x_ps_q      <= x_ps_d;
            y_ps_q      <= y_ps_d;
            col_q       <= col_d;
            row_q       <= row_d;
            setup_q     <= setup_d;
            pix_valid_q <= pix_valid_d;
            done_q      <= done_d;
        end
    end

    assign setup     = setup_q;
    assign x_ps      = x_ps_q;
    assign y_ps      = y_ps_q;
    assign pix_valid = pix_valid_q;
    assign pix_col   = col_q;
    assign pix_row   = row_q;
    assign done      = done_q;
    assign pix_last  = (col_q == COL_LAST) & (row_q == ROW_LAST) & pix_valid_q;

endmodule

// File: tb/tb_interp_tile_seq.sv
// Scoreboard bench for interp_tile_seq: stimulus queues expected pixels,
// setup cycles and done pulses; a negedge monitor pops and compares them.
module tb_interp_tile_seq;

    localparam int TW      = 32;
    localparam int TH      = 32;
    localparam int SC      = 4;
    localparam int CWID    = 11;
    localparam int ROW_CYC = SC + TW;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [CWID-1:0] tile_x = '0;
    logic [CWID-1:0] tile_y = '0;
    logic            abort = 1'b0;
    logic            setup;
    logic [CWID-1:0] x_ps;
    logic [CWID-1:0] y_ps;
    logic            pix_valid;
    logic            pix_ready = 1'b1;
    logic [4:0]      pix_col;
    logic [4:0]      pix_row;
    logic            pix_last;
    logic            done;

    interp_tile_seq #(
        .TILE_W       (TW),
        .TILE_H       (TH),
        .SETUP_CYCLES (SC),
        .COORD_W      (CWID)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .abort     (abort),
        .setup     (setup),
        .x_ps      (x_ps),
        .y_ps      (y_ps),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_col   (pix_col),
        .pix_row   (pix_row),
        .pix_last  (pix_last),
        .done      (done)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [4:0]  col;
        logic [4:0]  row;
        logic        last;
        int          cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t set_q[$];
    int   done_q[$];

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_xfer = 0;
    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [33:0] prev_vals = '0;
    pix_t        e;
    int          dcyc;

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Events seen at a negedge belong to the following rising edge, cyc+1.
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall && !prev_abort)
                check("stall_hold", {pix_valid, x_ps, y_ps, pix_col, pix_row, pix_last}, prev_vals);
            if (pix_valid && pix_ready) begin
                check("pix_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pix", {x_ps, y_ps, pix_col, pix_row, pix_last},
                          {e.x, e.y, e.col, e.row, e.last});
                    if (e.cyc >= 0) check("pix_cycle", cyc + 1, e.cyc);
                    n_xfer++;
                end
            end
            if (setup) begin
                check("setup_expected", set_q.size() > 0, 1);
                if (set_q.size() > 0) begin
                    e = set_q.pop_front();
                    check("setup", {x_ps, y_ps, pix_row, pix_valid}, {e.x, e.y, e.row, 1'b0});
                    if (e.cyc >= 0) check("setup_cycle", cyc + 1, e.cyc);
                end
            end
            if (done) begin
                check("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    dcyc = done_q.pop_front();
                    if (dcyc >= 0) check("done_cycle", cyc + 1, dcyc);
                end
            end
        end
        prev_stall = pix_valid && !pix_ready && !reset;
        prev_abort = abort;
        prev_vals  = {pix_valid, x_ps, y_ps, pix_col, pix_row, pix_last};
    end

    // acc < 0 disables cycle-exact checking (used under backpressure).
    task automatic push_job(input logic [10:0] bx, input logic [10:0] by, input int acc);
        for (int r = 0; r < TH; r++) begin
            for (int k = 0; k < SC; k++)
                set_q.push_back('{x: bx, y: 11'(by + r), col: 5'd0, row: 5'(r), last: 1'b0,
                                  cyc: (acc < 0) ? -1 : acc + 1 + ROW_CYC * r + k});
            for (int c = 0; c < TW; c++)
                exp_q.push_back('{x: 11'(bx + c), y: 11'(by + r), col: 5'(c), row: 5'(r),
                                  last: (r == TH - 1) && (c == TW - 1),
                                  cyc: (acc < 0) ? -1 : acc + SC + 1 + ROW_CYC * r + c});
        end
        done_q.push_back((acc < 0) ? -1 : acc + ROW_CYC * TH + 1);
    endtask

    task automatic flush();
        exp_q.delete();
        set_q.delete();
        done_q.delete();
    endtask

    task automatic start_job(input logic [10:0] bx, input logic [10:0] by, input logic timed,
                             output int acc);
        @(posedge clock); #1;
        check("job_ready_idle", job_ready, 1);
        tile_x    = bx;
        tile_y    = by;
        job_valid = 1'b1;
        acc       = cyc + 1;
        push_job(bx, by, timed ? acc : -1);
        @(posedge clock); #1;
        job_valid = 1'b0;
    endtask

    task automatic drain(input logic bp);
        int i = 0;
        while (i < 8000 && (exp_q.size() + set_q.size() + done_q.size()) != 0) begin
            @(posedge clock); #1;
            if (bp) pix_ready = 1'($urandom_range(0, 1));
            i++;
        end
        pix_ready = 1'b1;
        check("drain_left", exp_q.size() + set_q.size() + done_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int acc;
        int i;

        // Reset state.
        #12;
        check("rst_outputs", {setup, pix_valid, done, x_ps, y_ps, pix_col, pix_row, pix_last}, 0);
        check("rst_job_ready", job_ready, 1);
        #1 reset = 1'b0;

        // Single job, no backpressure, cycle-exact.
        n_xfer = 0;
        start_job(11'd64, 11'd32, 1'b1, acc);
        drain(1'b0);
        check("xfer_count_plain", n_xfer, 1024);
        check("done_single", done, 0);

        // Random backpressure.
        n_xfer = 0;
        start_job(11'd300, 11'd500, 1'b0, acc);
        drain(1'b1);
        check("xfer_count_bp", n_xfer, 1024);

        // Coordinate wrap on both axes.
        n_xfer = 0;
        start_job(11'd2032, 11'd2040, 1'b1, acc);
        drain(1'b0);
        check("xfer_count_wrap", n_xfer, 1024);

        // Abort during SETUP of row 5.
        start_job(11'd10, 11'd20, 1'b1, acc);
        i = 0;
        while (!(setup && pix_row == 5'd5) && i < 1000) begin
            @(posedge clock); #1;
            i++;
        end
        check("reach_row5_setup", {setup, pix_row}, {1'b1, 5'd5});
        abort = 1'b1;
        @(posedge clock); #1;
        check("abort_setup_drop", {setup, pix_valid, done}, 0);
        check("abort_masks_ready", job_ready, 0);
        abort = 1'b0;
        #1 check("ready_after_abort_setup", job_ready, 1);
        flush();
        idle_cycles(40);

        // Abort during a stalled SCAN.
        start_job(11'd100, 11'd100, 1'b1, acc);
        i = 0;
        while (!(pix_valid && pix_row == 5'd2 && pix_col == 5'd10) && i < 1000) begin
            @(posedge clock); #1;
            i++;
        end
        check("reach_scan_2_10", {pix_valid, pix_row, pix_col}, {1'b1, 5'd2, 5'd10});
        pix_ready = 1'b0;
        idle_cycles(3);
        check("stalled_pixel", {pix_valid, x_ps, y_ps, pix_col}, {1'b1, 11'd110, 11'd102, 5'd10});
        abort = 1'b1;
        @(posedge clock); #1;
        check("abort_scan_drop", {setup, pix_valid, done}, 0);
        abort     = 1'b0;
        pix_ready = 1'b1;
        #1 check("ready_after_abort_scan", job_ready, 1);
        flush();
        idle_cycles(40);

        // Back-to-back jobs with job_valid held high.
        @(posedge clock); #1;
        check("job_ready_b2b", job_ready, 1);
        tile_x    = 11'd400;
        tile_y    = 11'd8;
        job_valid = 1'b1;
        acc       = cyc + 1;
        push_job(11'd400, 11'd8, acc);
        push_job(11'd500, 11'd600, acc + ROW_CYC * TH + 1);
        @(posedge clock); #1;
        tile_x = 11'd500;
        tile_y = 11'd600;
        while (cyc < acc + ROW_CYC * TH) begin
            @(posedge clock); #1;
        end
        check("done_with_ready", {done, job_ready}, 2'b11);
        @(posedge clock); #1;
        job_valid = 1'b0;
        drain(1'b0);

        // Asynchronous reset mid-row, then a fresh job.
        start_job(11'd7, 11'd9, 1'b1, acc);
        i = 0;
        while (!(pix_valid && pix_row == 5'd3 && pix_col == 5'd5) && i < 1000) begin
            @(posedge clock); #1;
            i++;
        end
        check("reach_scan_3_5", {pix_valid, pix_row, pix_col}, {1'b1, 5'd3, 5'd5});
        #2 reset = 1'b1;
        #1;
        check("async_rst_outputs", {setup, pix_valid, done, x_ps, y_ps, pix_col, pix_row, pix_last}, 0);
        check("async_rst_ready", job_ready, 1);
        flush();
        @(posedge clock); #3 reset = 1'b0;
        n_xfer = 0;
        start_job(11'd1000, 11'd1000, 1'b1, acc);
        drain(1'b0);
        check("xfer_count_after_rst", n_xfer, 1024);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
